// File: rtl/tx_segmenter.sv
// tx_segmenter: splits application messages into packets of at most
// PACKET_SIZE beats. Each message keeps one tdest throughout. Reserved and
// empty keep patterns are rewritten. Output goes through a 2-entry skid buffer.
module tx_segmenter #(
   parameter int PACKET_SIZE = 22,
   parameter int DEST_WIDTH  = 16
) (
   input  logic                  aclk,
   input  logic                  areset,
   input  logic [511:0]          s_axis_tdata,
   input  logic [63:0]           s_axis_tkeep,
   input  logic [DEST_WIDTH-1:0] s_axis_tdest,
   input  logic                  s_axis_tvalid,
   input  logic                  s_axis_tlast,
   output logic                  s_axis_tready,
   output logic [511:0]          m_axis_tdata,
   output logic [63:0]           m_axis_tkeep,
   output logic [DEST_WIDTH-1:0] m_axis_tdest,
   output logic                  m_axis_tvalid,
   output logic                  m_axis_tlast,
   input  logic                  m_axis_tready,
   output logic [31:0]           seg_count,
   output logic [15:0]           keep_fix_count,
   output logic                  busy
);

   localparam logic [7:0]  LAST_IDX = 8'(PACKET_SIZE - 1);
   localparam logic [63:0] RSV_KEEP0 = 64'h0000_0000_00FF_FFFF;
   localparam logic [63:0] RSV_KEEP1 = 64'h0000_0000_FFFF_FFFF;

   typedef enum logic {IDLE, IN_MSG} state_t;

   typedef struct packed {
      logic [511:0]          data;
      logic [63:0]           keep;
      logic [DEST_WIDTH-1:0] dest;
      logic                  last;
   } beat_t;

   state_t                state_q, state_d;
   logic [7:0]            bcnt_q, bcnt_d;
   logic [DEST_WIDTH-1:0] dest_q, dest_d;
   logic [1:0]            cnt_q, cnt_d;
   logic                  wr_q, rd_q;
   logic                  s_rdy_q;
   logic [31:0]           seg_q;
   logic [15:0]           fix_q;
   beat_t                 mem_q [2];
   beat_t                 in_beat;
   logic                  s_fire, m_fire, drop, push, fix;

   assign s_fire = s_axis_tvalid & s_rdy_q;
   assign m_fire = m_axis_tvalid & m_axis_tready;
   // An empty non-final beat carries nothing, so it is swallowed here.
   assign drop   = (s_axis_tkeep == '0) & ~s_axis_tlast;
   assign push   = s_fire & ~drop;
   assign fix    = (s_axis_tkeep == RSV_KEEP0) || (s_axis_tkeep == RSV_KEEP1);

   // Ingress: rewrite keep/data, choose tdest, decide tlast, next FSM state.
   always_comb begin
      state_d      = state_q;
      bcnt_d       = bcnt_q;
      dest_d       = dest_q;
      in_beat.data = s_axis_tdata;
      in_beat.keep = s_axis_tkeep;
      in_beat.dest = (state_q == IDLE) ? s_axis_tdest : dest_q;
      in_beat.last = s_axis_tlast | (bcnt_q == LAST_IDX);
      if (fix) begin
         // Reserved control-frame keep: prepend a zero byte so it can't alias.
         in_beat.keep = {s_axis_tkeep[62:0], 1'b1};
         in_beat.data = {s_axis_tdata[503:0], 8'h00};
      end else if (s_axis_tkeep == '0) begin
         in_beat.keep      = 64'h1;
         in_beat.data[7:0] = 8'h00;
      end
      if (s_fire) begin
         if (state_q == IDLE) dest_d = s_axis_tdest;
         state_d = s_axis_tlast ? IDLE : IN_MSG;
      end
      if (push) bcnt_d = in_beat.last ? 8'd0 : bcnt_q + 8'd1;
   end

   // Skid buffer occupancy; ready is registered so it never depends on m_axis_tready.
   always_comb begin
      cnt_d = cnt_q;
      case ({push, m_fire})
         2'b10:   cnt_d = cnt_q + 2'd1;
         2'b01:   cnt_d = cnt_q - 2'd1;
         default: cnt_d = cnt_q;
      endcase
   end

   // Control state, pointers and counters.
   always_ff @(posedge aclk or posedge areset) begin
      if (areset) begin
         state_q <= IDLE;
         bcnt_q  <= '0;
         dest_q  <= '0;
         cnt_q   <= '0;
         wr_q    <= 1'b0;
         rd_q    <= 1'b0;
         s_rdy_q <= 1'b0;
         seg_q   <= '0;
         fix_q   <= '0;
      end else begin
         state_q <= state_d;
         bcnt_q  <= bcnt_d;
         dest_q  <= dest_d;
         cnt_q   <= cnt_d;
         s_rdy_q <= (cnt_d != 2'd2);
         if (push)   wr_q <= ~wr_q;
         if (m_fire) rd_q <= ~rd_q;
         if (m_fire && m_axis_tlast) seg_q <= seg_q + 32'd1;
         if (push && fix && fix_q != 16'hFFFF) fix_q <= fix_q + 16'd1;
      end
   end

   // Buffer storage; validity is tracked by cnt_q, so no reset needed.
   always_ff @(posedge aclk) begin
      if (push) mem_q[wr_q] <= in_beat;
   end

   assign s_axis_tready  = s_rdy_q;
   assign m_axis_tvalid  = (cnt_q != 2'd0);
   assign m_axis_tdata   = mem_q[rd_q].data;
   assign m_axis_tkeep   = mem_q[rd_q].keep;
   assign m_axis_tdest   = mem_q[rd_q].dest;
   assign m_axis_tlast   = mem_q[rd_q].last;
   assign seg_count      = seg_q;
   assign keep_fix_count = fix_q;
   assign busy           = (state_q == IN_MSG) || (cnt_q != 2'd0);

endmodule

// File: tb/tb_tx_segmenter.sv
// Bench for tx_segmenter: message-level model + per-beat scoreboard.
module tb_tx_segmenter;
   localparam int PS = 22;
   localparam int DW = 16;

   logic          aclk = 1'b0, areset = 1'b1;
   logic [511:0]  s_tdata = '0;
   logic [63:0]   s_tkeep = '0;
   logic [DW-1:0] s_tdest = '0;
   logic          s_tvalid = 1'b0, s_tlast = 1'b0, s_tready;
   logic [511:0]  m_tdata;
   logic [63:0]   m_tkeep;
   logic [DW-1:0] m_tdest;
   logic          m_tvalid, m_tlast;
   logic          m_tready = 1'b1;
   logic [31:0]   seg_count;
   logic [15:0]   keep_fix_count;
   logic          busy;

   tx_segmenter #(.PACKET_SIZE(PS), .DEST_WIDTH(DW)) dut (
      .aclk(aclk), .areset(areset),
      .s_axis_tdata(s_tdata), .s_axis_tkeep(s_tkeep), .s_axis_tdest(s_tdest),
      .s_axis_tvalid(s_tvalid), .s_axis_tlast(s_tlast), .s_axis_tready(s_tready),
      .m_axis_tdata(m_tdata), .m_axis_tkeep(m_tkeep), .m_axis_tdest(m_tdest),
      .m_axis_tvalid(m_tvalid), .m_axis_tlast(m_tlast), .m_axis_tready(m_tready),
      .seg_count(seg_count), .keep_fix_count(keep_fix_count), .busy(busy));

   always #5 aclk = ~aclk;

   typedef struct packed {
      logic [511:0]  d;
      logic [63:0]   k;
      logic [DW-1:0] dst;
      logic          l;
   } beat_t;

   int n_tests = 0, n_fail = 0;
   beat_t exp_q[$];
   beat_t obs[$];
   int    lastpos[$];
   int    out_cnt = 0;
   bit    msg_open = 0;
   int    pos = 0;
   logic [DW-1:0] msg_dest = '0;
   logic [31:0]   exp_seg = '0;
   logic [15:0]   exp_fix = '0;
   bit    rnd_ready = 0;
   bit    stall_prev = 0;
   beat_t held;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic chk_beat(input string name, input beat_t act, input beat_t exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got k=%0h dst=%0h l=%0b d=%0h expected k=%0h dst=%0h l=%0b d=%0h",
                  name, act.k, act.dst, act.l, act.d, exp.k, exp.dst, exp.l, exp.d);
      end
   endtask

   task automatic clear_model();
      exp_q.delete(); obs.delete(); lastpos.delete();
      out_cnt = 0; msg_open = 0; pos = 0; msg_dest = '0;
      exp_seg = '0; exp_fix = '0; stall_prev = 0;
   endtask

   // Model: for every accepted input beat, what the output stream must carry.
   always @(negedge aclk) begin
      if (!areset && s_tvalid && s_tready) begin
         beat_t e;
         if (!msg_open) msg_dest = s_tdest;
         msg_open = !s_tlast;
         if (!(s_tkeep == 64'h0 && !s_tlast)) begin
            e.dst = msg_dest;
            e.d   = s_tdata;
            e.k   = s_tkeep;
            if (s_tkeep == 64'hFF_FFFF || s_tkeep == 64'hFFFF_FFFF) begin
               e.k = (s_tkeep << 1) | 64'h1;
               e.d = s_tdata << 8;
               if (exp_fix != 16'hFFFF) exp_fix = exp_fix + 16'd1;
            end else if (s_tkeep == 64'h0) begin
               e.k = 64'h1;
               e.d[7:0] = 8'h00;
            end
            pos = pos + 1;                     // 1-based position inside packet
            e.l = s_tlast || (pos == PS);
            if (e.l) pos = 0;
            exp_q.push_back(e);
         end
      end
   end

   // Compare: every output handshake against the model; payload stable under stall.
   always @(negedge aclk) begin
      if (areset) begin
         stall_prev = 0;
      end else begin
         beat_t a;
         a = '{d: m_tdata, k: m_tkeep, dst: m_tdest, l: m_tlast};
         if (stall_prev) begin
            chk("stall_valid", {63'd0, m_tvalid}, 64'd1);
            chk_beat("stall_payload", a, held);
         end
         if (m_tvalid && m_tready) begin
            out_cnt++;
            if (exp_q.size() == 0) begin
               chk("unexpected_beat", 64'd1, 64'd0);
            end else begin
               chk_beat("out_beat", a, exp_q.pop_front());
            end
            obs.push_back(a);
            if (a.l) begin
               exp_seg = exp_seg + 32'd1;
               lastpos.push_back(out_cnt);
            end
         end
         stall_prev = m_tvalid && !m_tready;
         held = a;
      end
   end

   // Sink ready: always on, or 50% random.
   always @(posedge aclk) begin
      #1 m_tready = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
   end

   task automatic send(input logic [511:0] d, input logic [63:0] k,
                       input logic [DW-1:0] dst, input logic l);
      int t = 0;
      s_tdata = d; s_tkeep = k; s_tdest = dst; s_tlast = l; s_tvalid = 1'b1;
      forever begin
         @(negedge aclk);
         if (s_tready) break;
         t++;
         if (t > 1000) begin
            chk("send_timeout", 64'd1, 64'd0);
            break;
         end
      end
      @(posedge aclk);
      #1 s_tvalid = 1'b0;
   endtask

   task automatic drain();
      int t = 0;
      while ((exp_q.size() != 0 || m_tvalid) && t < 3000) begin
         @(posedge aclk); #1; t++;
      end
      chk("drain_done", 64'(exp_q.size()), 64'd0);
   endtask

   task automatic do_reset();
      areset = 1'b1; s_tvalid = 1'b0;
      clear_model();
      repeat (2) @(posedge aclk);
      #1 areset = 1'b0;
      @(posedge aclk); #1;
   endtask

   function automatic logic [511:0] pat(input int i);
      logic [511:0] v;
      for (int b = 0; b < 16; b++) v[b*32 +: 32] = 32'(i * 131 + b * 7919 + 32'hA5A5_0000);
      return v;
   endfunction

   initial begin
      // reset state
      #2;
      chk("rst_m_tvalid", {63'd0, m_tvalid}, 64'd0);
      chk("rst_s_tready", {63'd0, s_tready}, 64'd0);
      chk("rst_busy", {63'd0, busy}, 64'd0);
      chk("rst_seg", 64'(seg_count), 64'd0);
      chk("rst_fix", 64'(keep_fix_count), 64'd0);
      repeat (2) @(posedge aclk);
      #1 areset = 1'b0;
      chk("tready_before_edge", {63'd0, s_tready}, 64'd0);
      @(posedge aclk); #1;
      chk("tready_after_edge", {63'd0, s_tready}, 64'd1);

      // 5-beat message, dest 3
      send(pat(0), '1, 16'h0003, 1'b0);
      chk("first_latency", {63'd0, m_tvalid}, 64'd1);
      chk("busy_mid_msg", {63'd0, busy}, 64'd1);
      for (int i = 1; i < 5; i++) send(pat(i), '1, 16'h0003, i == 4);
      drain();
      chk("m5_seg", 64'(seg_count), 64'd1);
      chk("m5_outs", 64'(obs.size()), 64'd5);
      chk("m5_lastpos", 64'(lastpos[0]), 64'd5);
      chk("m5_dest4", 64'(obs[4].dst), 64'h3);
      chk("m5_busy_idle", {63'd0, busy}, 64'd0);

      // 50-beat message: 22/22/6, input dest wanders after beat 1
      do_reset();
      for (int i = 0; i < 50; i++)
         send(pat(100 + i), '1, (i == 0) ? 16'h0042 : 16'(i * 17), i == 49);
      drain();
      chk("m50_seg", 64'(seg_count), 64'd3);
      chk("m50_nlast", 64'(lastpos.size()), 64'd3);
      chk("m50_last0", 64'(lastpos[0]), 64'd22);
      chk("m50_last1", 64'(lastpos[1]), 64'd44);
      chk("m50_last2", 64'(lastpos[2]), 64'd50);
      chk("m50_dest_end", 64'(obs[49].dst), 64'h42);

      // 22-beat message with input tlast on beat 22
      do_reset();
      for (int i = 0; i < 22; i++) send(pat(200 + i), '1, 16'h0007, i == 21);
      drain();
      chk("m22_seg", 64'(seg_count), 64'd1);
      chk("m22_outs", 64'(obs.size()), 64'd22);

      // keep rewriting and dropping
      do_reset();
      send(pat(300), '1, 16'h0011, 1'b0);
      send(pat(301), 64'hFF_FFFF, 16'h0011, 1'b0);
      send(pat(302), 64'h0, 16'h0011, 1'b0);
      send(pat(303), '1, 16'h0011, 1'b1);
      send(pat(304), 64'hFFFF_FFFF, 16'h0012, 1'b0);
      send(pat(305), 64'h0, 16'h0012, 1'b1);
      drain();
      chk("kp_outs", 64'(obs.size()), 64'd5);
      chk("kp_keep24", obs[1].k, 64'h1FF_FFFF);
      chk("kp_byte0", 64'(obs[1].d[7:0]), 64'h0);
      chk("kp_byte1", 64'(obs[1].d[15:8]), 64'(pat(301) & 512'hFF));
      chk("kp_keep32", obs[3].k, 64'h1_FFFF_FFFF);
      chk("kp_keep0_last", obs[4].k, 64'h1);
      chk("kp_keep0_tlast", {63'd0, obs[4].l}, 64'd1);
      chk("kp_fix", 64'(keep_fix_count), 64'd2);
      chk("kp_seg", 64'(seg_count), 64'd2);

      // reset in mid-packet, then a fresh 22-beat message
      do_reset();
      for (int i = 0; i < 6; i++)
         send(pat(400 + i), (i == 2) ? 64'hFF_FFFF : '1, 16'h0AAA, 1'b0);
      s_tdata = pat(406); s_tkeep = '1; s_tdest = 16'h0AAA; s_tlast = 1'b0; s_tvalid = 1'b1;
      #2 areset = 1'b1;
      clear_model();
      #1;
      chk("mr_m_tvalid", {63'd0, m_tvalid}, 64'd0);
      chk("mr_s_tready", {63'd0, s_tready}, 64'd0);
      chk("mr_busy", {63'd0, busy}, 64'd0);
      chk("mr_fix", 64'(keep_fix_count), 64'd0);
      s_tvalid = 1'b0;
      @(posedge aclk);
      #1 areset = 1'b0;
      @(posedge aclk); #1;
      for (int i = 0; i < 22; i++) send(pat(500 + i), '1, (i == 0) ? 16'h0BBB : 16'h0CCC, i == 21);
      drain();
      chk("mr_seg", 64'(seg_count), 64'd1);
      chk("mr_dest", 64'(obs[0].dst), 64'h0BBB);

      // random traffic with backpressure
      do_reset();
      rnd_ready = 1;
      for (int i = 0; i < 10000; i++) begin
         logic [63:0] k;
         case ($urandom_range(0, 9))
            0:       k = 64'hFF_FFFF;
            1:       k = 64'hFFFF_FFFF;
            2:       k = 64'h0;
            3:       k = {$urandom, $urandom};
            default: k = '1;
         endcase
         if ($urandom_range(0, 1) == 1) begin
            @(posedge aclk); #1;
         end
         send({16{$urandom}}, k, 16'($urandom), $urandom_range(0, 29) == 0);
      end
      rnd_ready = 0;
      drain();
      chk("rnd_seg", 64'(seg_count), 64'(exp_seg));
      chk("rnd_fix", 64'(keep_fix_count), 64'(exp_fix));

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #5_000_000;
      $display("FAIL global_timeout: simulation did not complete");
      $fatal(1);
   end
endmodule

// File: doc/tx_segmenter.md
TX_SEGMENTER -- requirements
Module: tx_segmenter

Interface
REQ-001 Parameter PACKET_SIZE, default 22: maximum beats per emitted packet, legal range 2..255.
REQ-002 Parameter DEST_WIDTH, default 16: tdest width.
REQ-003 aclk  in  1: single clock; all logic is rising-edge.
REQ-004 areset  in  1: reset, asynchronous and active-high.
REQ-005 s_axis_tdata / tkeep / tdest / tvalid / tlast  in  512 / 64 / DEST_WIDTH / 1 / 1: application message stream; tready is an output of width 1.
REQ-006 m_axis_tdata / tkeep / tdest / tvalid / tlast  out  512 / 64 / DEST_WIDTH / 1 / 1: packet stream to the arbiter app-to-net TX input; tready is an input of width 1.
REQ-007 seg_count  out  32: packets emitted, counted on each m_axis beat accepted with tlast=1.
REQ-008 keep_fix_count  out  16: count of beats whose tkeep was promoted (REQ-015).
REQ-009 busy  out  1: high while a message is open (state IN_MSG) or the buffer holds data.

Function
REQ-010 Datapath: 2-entry skid buffer; one transfer per cycle sustained; first-beat latency is 1 cycle from s-side acceptance to m_axis_tvalid.
REQ-011 s_axis_tready is high iff the skid buffer has a free entry; it is not combinationally dependent on m_axis_tready.
REQ-012 State machine: IDLE -> IN_MSG on any accepted beat with tlast=0; IN_MSG -> IDLE on an accepted beat with tlast=1; otherwise hold.
REQ-013 tdest is latched from the first beat accepted in IDLE; all beats of that message are emitted with the latched tdest, even if s_axis_tdest changes mid-message.
REQ-014 Beat counter (8 bit) is 0 at message start and increments per accepted beat; output tlast = input tlast OR (counter == PACKET_SIZE-1); the counter returns to 0 after any beat emitted with tlast=1; the message then continues in IN_MSG with the same tdest.
REQ-015 Reserved keep patterns 64'h0000_0000_00FF_FFFF and 64'h0000_0000_FFFF_FFFF (arbiter control frames) are never emitted; such beats are emitted with keep shifted left one bit with bit 0 set (0x1FF_FFFF / 0x1_FFFF_FFFF), the added byte forced to 0x00, and keep_fix_count incremented.
REQ-016 A beat with tkeep == 0 and tlast = 0 is accepted and dropped, and does not advance the beat counter; tkeep == 0 with tlast = 1 is emitted with tkeep 64'h1, data byte 0 forced to 0x00.
REQ-017 m_axis payload is held stable while m_axis_tvalid=1 and m_axis_tready=0.
REQ-018 keep_fix_count saturates at 16'hFFFF; seg_count wraps modulo 2^32.
REQ-019 Input tlast coinciding with counter == PACKET_SIZE-1: a single tlast beat is emitted, with no empty extra packet.

Reset
REQ-020 areset asserted at any time immediately clears: m_axis_tvalid=0, s_axis_tready=0, buffer empty, state IDLE, beat counter 0, latched tdest 0, seg_count=0, keep_fix_count=0, busy=0.
REQ-021 s_axis_tready rises on the first aclk edge after areset deasserts; a packet in flight at reset is discarded, not completed.

Verification
REQ-022 5-beat message, dest 0x0003, tlast on beat 5, m_tready=1 -> 5 beats out, all with dest 0x0003, tlast only on beat 5, seg_count=1, first output one cycle after first accept.
REQ-023 50-beat message, PACKET_SIZE=22 -> packets of 22/22/6 beats, tlast on beats 22, 44 and 50, seg_count=3, same tdest throughout.
REQ-024 22-beat message with tlast on beat 22 -> exactly one packet, seg_count=1 (REQ-019).
REQ-025 Beat with tkeep 0xFFFFFF -> emitted keep 0x1FFFFFF, byte 0 = 0x00, keep_fix_count=1; tkeep 0 with tlast=0 mid-message -> no output beat.
REQ-026 Random m_tready (50%) and random s_tvalid over 10k beats -> output equals the reference model, no beat lost or duplicated, payload stable under backpressure.
REQ-027 areset pulsed mid-packet (beat 7 of 22) -> outputs cleared within the same cycle; the next message starts with beat counter 0 and a newly latched tdest.
